// File: rtl/rv32_fetch_unit.sv
// RV32 instruction fetch unit: in-order prefetch into a small FIFO, with
// redirect flush, in-flight response discard and a misaligned-target fault state.
module rv32_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned AW           = 32,
    parameter int unsigned DEPTH        = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rsp_valid,
    input  logic [31:0]   imem_rsp_data,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [31:0]   inst_data,
    output logic [AW-1:0] inst_pc,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          fetch_fault,
    output logic [AW-1:0] fault_pc
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned CW      = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);
    localparam logic [AW-1:0] RV    = RESET_VECTOR[AW-1:0];
    localparam logic [AW-1:0] STEP  = AW'(4);

    typedef enum logic {RUN, FAULT} state_t;

    state_t        state_q, state_n;
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] fifo_pc   [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, outstanding, discard;
    logic [AW-1:0] fpc, rsp_pc, fault_pc_q;
    logic          req_fire, rsp_keep, rsp_drop, pop, redirect_aligned;

    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign rsp_keep         = imem_rsp_valid && (discard == '0);
    assign rsp_drop         = imem_rsp_valid && (discard != '0);
    assign pop              = inst_valid && inst_ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        if (redirect_valid) state_n = redirect_aligned ? RUN : FAULT;
    end

    // Occupancy plus in-flight never exceeds DEPTH, so every response has a slot.
    always_comb begin
        imem_req_valid = 1'b0;
        fetch_fault    = 1'b0;
        case (state_q)
            RUN:   imem_req_valid = !reset && (discard == '0) &&
                                    (({1'b0, count} + {1'b0, outstanding}) < DEPTH_L);
            FAULT: fetch_fault = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        imem_addr  = fpc;
        inst_valid = (count != '0);
        inst_data  = fifo_data[rd_ptr];
        inst_pc    = fifo_pc[rd_ptr];
        fault_pc   = fault_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            fifo_data[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end

    // rsp_pc tracks the address of the next response that will be kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc         <= RV;
            rsp_pc      <= RV;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            fault_pc_q  <= '0;
        end else if (redirect_valid) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            // Everything still in flight after this edge must be dropped.
            discard     <= discard + outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_aligned) begin
                fpc    <= redirect_pc;
                rsp_pc <= redirect_pc;
            end else begin
                fault_pc_q <= redirect_pc;
            end
        end else begin
            if (req_fire) fpc <= fpc + STEP;
            if (rsp_drop) discard <= discard - CW'(1);
            if (rsp_keep) begin
                wr_ptr <= wr_ptr + PW'(1);
                rsp_pc <= rsp_pc + STEP;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
            count       <= count + CW'(rsp_keep) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Directed bench for rv32_fetch_unit: per-cycle vector table on a default
// instance plus hand sequences for long-latency redirect and an 8-bit wrap instance.
module tb_rv32_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    logic        reset, imem_req_valid, imem_req_ready, inst_valid, inst_ready;
    logic        redirect_valid, fetch_fault;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic [31:0] imem_addr, inst_data, inst_pc, redirect_pc, fault_pc;

    logic        w_req_valid, w_req_ready, w_inst_valid, w_inst_ready;
    logic        w_redirect_valid, w_fault;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data  = '0;
    logic [31:0] w_inst_data;
    logic [7:0]  w_addr, w_inst_pc, w_redirect_pc, w_fault_pc;

    rv32_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .AW(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault), .fault_pc(fault_pc)
    );

    rv32_fetch_unit #(.RESET_VECTOR(32'h0000_00F8), .AW(8), .DEPTH(4)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst_data(w_inst_data), .inst_pc(w_inst_pc),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .fetch_fault(w_fault), .fault_pc(w_fault_pc)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    // In-order memory with configurable latency for the main instance.
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;
    pend_t       pq[$];
    int unsigned cyc     = 0;
    int unsigned mem_lat = 1;

    always @(posedge clk) begin
        if (reset) pq.delete();
        else begin
            if (imem_rsp_valid && pq.size() != 0) void'(pq.pop_front());
            if (imem_req_valid && imem_req_ready) pq.push_back('{addr: imem_addr, due: cyc + mem_lat});
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (pq.size() != 0 && pq[0].due <= cyc) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mem_word(pq[0].addr);
        end else begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end
    end

    // Latency-1 always-ready memory for the wrap instance.
    logic       w_acc      = 1'b0;
    logic [7:0] w_acc_addr = '0;
    always @(posedge clk) begin
        w_acc      <= w_req_valid && w_req_ready;
        w_acc_addr <= w_addr;
    end
    always @(negedge clk) begin
        w_rsp_valid <= w_acc;
        w_rsp_data  <= {24'hC3C3C3, w_acc_addr};
    end

    typedef struct {
        bit          rst, rdy, rdv;
        logic [31:0] rpc;
        bit          req;
        logic [31:0] addr;
        bit          iv;
        logic [31:0] pc;
        bit          flt, chkf;
        logic [31:0] fpc;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(input bit rst, input bit rdy, input bit rdv, input logic [31:0] rpc,
                                input bit req, input logic [31:0] addr, input bit iv, input logic [31:0] pc,
                                input bit flt, input bit chkf, input logic [31:0] fpc);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.rdv = rdv; t.rpc = rpc;
        t.req = req; t.addr = addr; t.iv = iv; t.pc = pc;
        t.flt = flt; t.chkf = chkf; t.fpc = fpc;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    logic [7:0] wa [4] = '{8'hF8, 8'hFC, 8'h00, 8'h04};
    logic       found;

    initial begin
        reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1;
        w_req_ready = 1'b1; w_inst_ready = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = '0;

        // rst rdy rdv rpc | req addr | iv pc | flt chkf fpc
        // Streaming, latency 1, decode always ready
        vt.push_back(mk(Y,Y,N,0, N,0,     N,0,     N,Y,0));
        vt.push_back(mk(N,Y,N,0, Y,32'h00, N,0,     N,N,0));
        vt.push_back(mk(N,Y,N,0, Y,32'h04, N,0,     N,N,0));
        vt.push_back(mk(N,Y,N,0, Y,32'h08, Y,32'h00, N,N,0));
        vt.push_back(mk(N,Y,N,0, Y,32'h0C, Y,32'h04, N,N,0));
        vt.push_back(mk(N,Y,N,0, Y,32'h10, Y,32'h08, N,N,0));
        vt.push_back(mk(N,Y,N,0, Y,32'h14, Y,32'h0C, N,N,0));
        // Reset, then backpressure from the start: four requests then stall, resume at 0x10
        vt.push_back(mk(Y,N,N,0, N,0,     Y,32'h10, N,N,0));
        vt.push_back(mk(N,N,N,0, Y,32'h00, N,0,     N,N,0));
        vt.push_back(mk(N,N,N,0, Y,32'h04, N,0,     N,N,0));
        vt.push_back(mk(N,N,N,0, Y,32'h08, Y,32'h00, N,N,0));
        vt.push_back(mk(N,N,N,0, Y,32'h0C, Y,32'h00, N,N,0));
        vt.push_back(mk(N,N,N,0, N,0,     Y,32'h00, N,N,0));
        vt.push_back(mk(N,N,N,0, N,0,     Y,32'h00, N,N,0));
        vt.push_back(mk(N,Y,N,0, N,0,     Y,32'h00, N,N,0));
        vt.push_back(mk(N,Y,N,0, Y,32'h10, Y,32'h04, N,N,0));
        vt.push_back(mk(N,Y,N,0, Y,32'h14, Y,32'h08, N,N,0));
        vt.push_back(mk(N,Y,N,0, Y,32'h18, Y,32'h0C, N,N,0));
        vt.push_back(mk(N,Y,N,0, Y,32'h1C, Y,32'h10, N,N,0));
        // Reset mid-stream, refill to full, reset with full FIFO
        vt.push_back(mk(Y,N,N,0, N,0,     Y,32'h14, N,N,0));
        vt.push_back(mk(N,N,N,0, Y,32'h00, N,0,     N,N,0));
        vt.push_back(mk(N,N,N,0, Y,32'h04, N,0,     N,N,0));
        vt.push_back(mk(N,N,N,0, Y,32'h08, Y,32'h00, N,N,0));
        vt.push_back(mk(N,N,N,0, Y,32'h0C, Y,32'h00, N,N,0));
        vt.push_back(mk(N,N,N,0, N,0,     Y,32'h00, N,N,0));
        vt.push_back(mk(N,N,N,0, N,0,     Y,32'h00, N,N,0));
        vt.push_back(mk(Y,N,N,0, N,0,     Y,32'h00, N,N,0));
        vt.push_back(mk(N,N,N,0, Y,32'h00, N,0,     N,N,0));
        // Misaligned redirect, re-fault in FAULT, aligned redirect recovers
        vt.push_back(mk(N,Y,Y,32'h202, Y,32'h04, N,0, N,N,0));
        vt.push_back(mk(N,Y,N,0,       N,0,     N,0, Y,Y,32'h202));
        vt.push_back(mk(N,Y,Y,32'h207, N,0,     N,0, Y,Y,32'h202));
        vt.push_back(mk(N,Y,Y,32'h300, N,0,     N,0, Y,Y,32'h207));
        vt.push_back(mk(N,Y,N,0, Y,32'h300, N,0,      N,N,0));
        vt.push_back(mk(N,Y,N,0, Y,32'h304, N,0,      N,N,0));
        vt.push_back(mk(N,Y,N,0, Y,32'h308, Y,32'h300, N,N,0));
        // Reset clears fault_pc
        vt.push_back(mk(Y,Y,N,0, N,0,     Y,32'h304, N,N,0));
        vt.push_back(mk(N,Y,N,0, Y,32'h00, N,0,      N,Y,0));

        repeat (3) @(negedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            reset          = vt[i].rst;
            inst_ready     = vt[i].rdy;
            redirect_valid = vt[i].rdv;
            redirect_pc    = vt[i].rpc;
            #1;
            check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vt[i].req));
            if (vt[i].req) check($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
            check($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(vt[i].iv));
            if (vt[i].iv) begin
                check($sformatf("v%0d_inst_pc", i), inst_pc, vt[i].pc);
                check($sformatf("v%0d_inst_data", i), inst_data, mem_word(vt[i].pc));
            end
            check($sformatf("v%0d_fault", i), 32'(fetch_fault), 32'(vt[i].flt));
            if (vt[i].chkf) check($sformatf("v%0d_fault_pc", i), fault_pc, vt[i].fpc);
        end

        // Redirect with two requests in flight at latency 3
        mem_lat = 3; inst_ready = 1'b1; imem_req_ready = 1'b1;
        do_reset();
        check("lat3_c0_req", 32'(imem_req_valid), 32'd1);
        check("lat3_c0_addr", imem_addr, 32'h0);
        tick();
        check("lat3_c1_req", 32'(imem_req_valid), 32'd1);
        check("lat3_c1_addr", imem_addr, 32'h4);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h100; imem_req_ready = 1'b0;
        #1;
        check("lat3_c2_req", 32'(imem_req_valid), 32'd1);
        check("lat3_c2_addr", imem_addr, 32'h8);
        @(negedge clk);
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #1;
        check("lat3_discard1_req", 32'(imem_req_valid), 32'd0);
        check("lat3_flush_iv", 32'(inst_valid), 32'd0);
        tick();
        check("lat3_discard2_req", 32'(imem_req_valid), 32'd0);
        tick();
        check("lat3_resume_req", 32'(imem_req_valid), 32'd1);
        check("lat3_resume_addr", imem_addr, 32'h100);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            tick();
            if (inst_valid) found = 1'b1;
        end
        check("lat3_delivery_seen", 32'(found), 32'd1);
        if (found) begin
            check("lat3_first_pc", inst_pc, 32'h100);
            check("lat3_first_data", inst_data, mem_word(32'h100));
        end

        // AW=8 address wrap on the second instance
        mem_lat = 1;
        do_reset();
        check("wrap_fault", 32'(w_fault), 32'd0);
        check("wrap_fault_pc", 32'(w_fault_pc), 32'd0);
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                check($sformatf("wrap_req_%0d", k), 32'(w_req_valid), 32'd1);
                check($sformatf("wrap_addr_%0d", k), 32'(w_addr), 32'(wa[k]));
            end
            if (k >= 2) begin
                check($sformatf("wrap_iv_%0d", k), 32'(w_inst_valid), 32'd1);
                check($sformatf("wrap_pc_%0d", k), 32'(w_inst_pc), 32'(wa[k-2]));
                check($sformatf("wrap_data_%0d", k), w_inst_data, {24'hC3C3C3, wa[k-2]});
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
